// File: rtl/addr4u_sum_checker.sv
// Concurrent checker for an unsigned 4-bit adder: recomputes a+b for each accepted
// transaction, reports mismatch/syndrome, and tracks adder health with a saturating error count.
module addr4u_sum_checker #(
  parameter int CNT_W        = 8,
  parameter int ALARM_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [4:0]       sum,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mismatch,
  output logic [4:0]       out_syndrome,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       health,
  output logic             alarm
);

  typedef enum logic [1:0] {
    H_OK       = 2'b00,
    H_DEGRADED = 2'b01,
    H_ALARM    = 2'b10
  } health_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ALARM_THRESH);

  logic             r_out_valid;
  logic             r_mismatch;
  logic [4:0]       r_syndrome;
  logic [CNT_W-1:0] r_err_count;
  health_e          r_health;
  logic             r_alarm;

  logic             w_accept;
  logic [4:0]       w_expected;
  logic [4:0]       w_syndrome;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_count_next;
  health_e          w_health_next;

  // A full result slot can still accept when the consumer drains it in the same cycle.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;

  // Operands are zero-extended so the carry lands in bit 4; 15+15 cannot overflow 5 bits.
  assign w_expected = {1'b0, a} + {1'b0, b};
  assign w_syndrome = sum ^ w_expected;
  assign w_mismatch = |w_syndrome;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    w_count_next  = r_err_count;
    w_health_next = r_health;
    if (clr) begin
      w_count_next  = '0;
      w_health_next = H_OK;
    end else if (w_accept && w_mismatch) begin
      w_count_next = (r_err_count == CNT_MAX) ? r_err_count : r_err_count + 1'b1;
      if (w_count_next >= THRESH_C) begin
        w_health_next = H_ALARM;
      end else if (r_health == H_OK) begin
        w_health_next = H_DEGRADED;
      end
    end
  end

  // Result slot: loads on accept, empties when the consumer takes it, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_mismatch  <= 1'b0;
      r_syndrome  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_mismatch  <= w_mismatch;
      r_syndrome  <= w_syndrome;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Health tracking; ALARM only ever leaves through clr or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
      r_health    <= H_OK;
      r_alarm     <= 1'b0;
    end else begin
      r_err_count <= w_count_next;
      r_health    <= w_health_next;
      r_alarm     <= (w_health_next == H_ALARM);
    end
  end

  assign out_valid    = r_out_valid;
  assign out_mismatch = r_mismatch;
  assign out_syndrome = r_syndrome;
  assign err_count    = r_err_count;
  assign health       = r_health;
  assign alarm        = r_alarm;

endmodule
